// File: rtl/memory_reader_pkg.sv
// Shared definitions for memory_reader: FSM state encoding and default bank geometry
// (the same constants the bank wrapper uses).
package memory_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_WIDTH  = 8;

endpackage

// File: rtl/memory_reader_byte_select.sv
// Combinational DEPTH:1 byte mux from the flattened latch bank.
module memory_reader_byte_select
  import memory_reader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic [DEPTH*WIDTH-1:0] bank,
  input  logic [ADDR_W-1:0]      addr,
  output logic [WIDTH-1:0]       data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) data = bank[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Walks a run of consecutive bank addresses and streams each byte over valid/ready.
// Optional even-parity output rd_parity is enabled by defining MEMORY_READER_PARITY_EN.
//
// Output handshake: a byte transfers on a rising edge where rd_valid && rd_ready;
// once rd_valid is high, rd_data/rd_addr are held stable until that transfer.
module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      first_addr,
  input  logic [ADDR_W:0]        count,
  input  logic [DEPTH*WIDTH-1:0] bank,
  output logic [WIDTH-1:0]       rd_data,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   busy,
  output state_t                 dbg_state,
  output logic                   done
`ifdef MEMORY_READER_PARITY_EN
  ,
  output logic                   rd_parity
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     count_clamped;
  logic [WIDTH-1:0]    sel_byte;
  logic                xfer;

  memory_reader_byte_select #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WIDTH)
  ) u_byte_select (
    .bank (bank),
    .addr (addr),
    .data (sel_byte)
  );

  assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
  assign xfer          = rd_valid && rd_ready;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (count_clamped == '0) ? S_DONE : S_LOAD;
      S_LOAD: state_nxt = S_SEND;
      S_SEND: if (xfer) state_nxt = (remaining == ONE_C) ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_addr   <= '0;
      rd_valid  <= 1'b0;
`ifdef MEMORY_READER_PARITY_EN
      rd_parity <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= first_addr;
            remaining <= count_clamped;
          end
        end
        // Bank is sampled here, not at start, so updates between bytes are seen.
        S_LOAD: begin
          rd_data  <= sel_byte;
          rd_addr  <= addr;
          rd_valid <= 1'b1;
`ifdef MEMORY_READER_PARITY_EN
          rd_parity <= ^sel_byte;
`endif
        end
        S_SEND: begin
          if (xfer) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - ONE_C;
            addr      <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_reader.sv
// Scoreboard bench for memory_reader: directed runs push hand-computed {addr,data} entries,
// a negedge monitor pops and compares on every accepted byte.
module tb_memory_reader;
  import memory_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  first_addr;
  logic [2:0]  count;
  logic [31:0] bank;
  logic [7:0]  rd_data;
  logic [1:0]  rd_addr;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;
  state_t      dbg_state;
`ifdef MEMORY_READER_PARITY_EN
  logic        rd_parity;
`endif

  memory_reader #(.DEPTH(4), .ADDR_W(2), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .bank       (bank),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .done       (done)
`ifdef MEMORY_READER_PARITY_EN
    ,
    .rd_parity  (rd_parity)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (rd_valid) valid_cycles++;
      if (rd_valid && rd_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h@%0d, expected no byte", rd_data, rd_addr);
        end else begin
          mon_exp = exp_q.pop_front();
          check("byte_addr_data", {22'd0, rd_addr, rd_data}, {22'd0, mon_exp});
`ifdef MEMORY_READER_PARITY_EN
          check("parity", {31'd0, rd_parity}, {31'd0, ^mon_exp[7:0]});
`endif
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start(input logic [1:0] fa, input logic [2:0] cnt);
    @(posedge clk); #1;
    first_addr = fa;
    count      = cnt;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 after 200 cycles, expected idle", name);
    end
  endtask

  task automatic run(input string name, input logic [1:0] fa, input logic [2:0] cnt);
    int d0;
    d0 = done_cnt;
    pulse_start(fa, cnt);
    wait_idle(name);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_busy_after"}, {31'd0, busy}, 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int v0;
    int h0;
    bit ok;
    reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; rd_ready = 1'b1;
    bank  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {18'd0, rd_data, rd_addr, rd_valid, busy, done, 1'b0},
          {18'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    reset = 1'b0;

    // 1 basic run
    push(2'd0, 8'hA1); push(2'd1, 8'hB2); push(2'd2, 8'hC3);
    run("basic", 2'd0, 3'd3);

    // 2 wrap-around
    push(2'd3, 8'hD4); push(2'd0, 8'hA1);
    run("wrap", 2'd3, 3'd2);

    // 3 backpressure
    rd_ready = 1'b0;
    push(2'd2, 8'hC3);
    d0 = done_cnt;
    pulse_start(2'd2, 3'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid) begin ok = 1'b1; break; end
    end
    check("bp_valid_seen", {31'd0, ok}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {21'd0, rd_valid, rd_addr, rd_data}, {21'd0, 1'b1, 2'd2, 8'hC3});
    end
    @(posedge clk); #1;
    h0 = hs_cnt;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_consumed_first_cycle", hs_cnt - h0, 1);
    check("bp_valid_dropped", {31'd0, rd_valid}, 0);
    wait_idle("bp");
    check("bp_done_pulses", done_cnt - d0, 1);
    check("bp_drained", exp_q.size(), 0);

    // 4a count = 0
    d0 = done_cnt;
    v0 = valid_cycles;
    pulse_start(2'd1, 3'd0);
    @(negedge clk);
    check("cnt0_done_now", {31'd0, done}, 1);
    wait_idle("cnt0");
    check("cnt0_done_pulses", done_cnt - d0, 1);
    check("cnt0_no_valid", valid_cycles - v0, 0);

    // 4b count = 7 clamps to 4
    push(2'd2, 8'hC3); push(2'd3, 8'hD4); push(2'd0, 8'hA1); push(2'd1, 8'hB2);
    run("clamp", 2'd2, 3'd7);

    // 4c start while busy is ignored
    push(2'd1, 8'hB2); push(2'd2, 8'hC3);
    d0 = done_cnt;
    pulse_start(2'd1, 3'd2);
    pulse_start(2'd0, 3'd4);
    wait_idle("busy_start");
    check("busy_start_done_pulses", done_cnt - d0, 1);
    check("busy_start_drained", exp_q.size(), 0);

    // 5 reset mid-run, in SEND after the second byte
    push(2'd0, 8'hA1); push(2'd1, 8'hB2);
    h0 = hs_cnt;
    pulse_start(2'd0, 3'd4);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - h0 >= 2) begin ok = 1'b1; break; end
    end
    check("rst_two_bytes", {31'd0, ok}, 1);
    rd_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rd_valid) begin ok = 1'b1; break; end
    end
    check("rst_third_valid", {31'd0, ok}, 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("rst_outputs_zero", {19'd0, rd_data, rd_addr, rd_valid, busy, done},
          {19'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0});
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    push(2'd0, 8'hA1); push(2'd1, 8'hB2); push(2'd2, 8'hC3);
    run("after_reset", 2'd0, 3'd3);

`ifdef MEMORY_READER_PARITY_EN
    // 6 parity
    bank = {8'hD4, 8'hC3, 8'h03, 8'h07};
    push(2'd0, 8'h07); push(2'd1, 8'h03);
    rd_ready = 1'b0;
    pulse_start(2'd0, 3'd2);
    @(posedge clk); #1;
    check("parity_07", {31'd0, rd_parity}, 1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    check("parity_03", {31'd0, rd_parity}, 0);
    rd_ready = 1'b1;
    wait_idle("parity");
    check("parity_drained", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
